// File: rtl/button_conditioner_if.sv
// Button-side bundle of the conditioner: raw levels and repeat enable in,
// debounced levels and command pulses out.
interface button_conditioner_if #(
    parameter int N_BTN = 4
) ();
    logic [N_BTN-1:0] btn_raw;
    logic             repeat_en;
    logic [N_BTN-1:0] level;
    logic [N_BTN-1:0] pulse;

    modport master (
        output btn_raw,
        output repeat_en,
        input  level,
        input  pulse
    );

    modport slave (
        input  btn_raw,
        input  repeat_en,
        output level,
        output pulse
    );
endinterface

// File: rtl/button_conditioner.sv
// Per-button synchronizer, debouncer and press/auto-repeat pulse generator
// feeding the set inputs of the countdown clock core.
module button_conditioner #(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 1250000,
    parameter int REPEAT_DELAY    = 62500000,
    parameter int REPEAT_PERIOD   = 12500000
) (
    input  logic                 clk,
    input  logic                 rst,
    button_conditioner_if.slave  bus
);
    localparam int DW   = $clog2(DEBOUNCE_CYCLES);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX);

    localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    logic [N_BTN-1:0] sync1_r;
    logic [N_BTN-1:0] sync2_r;
    logic [N_BTN-1:0] level_s;
    logic [N_BTN-1:0] pulse_s;

    // Two-flop synchronizer for the asynchronous button levels
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= {N_BTN{1'b0}};
            sync2_r <= {N_BTN{1'b0}};
        end else begin
            sync1_r <= bus.btn_raw;
            sync2_r <= sync1_r;
        end
    end

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        logic [DW-1:0] dcnt_r;
        logic          level_r;
        state_t        state_r;
        state_t        state_s;
        logic [RW-1:0] rcnt_r;
        logic [RW-1:0] rcnt_s;
        logic          pulse_r;
        logic          fire_s;

        // Debounce: accept a new level only after DEBOUNCE_CYCLES disagreeing samples in a row
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dcnt_r  <= {DW{1'b0}};
                level_r <= 1'b0;
            end else if (sync2_r[g] == level_r) begin
                dcnt_r  <= {DW{1'b0}};
            end else if (dcnt_r == DB_LAST) begin
                level_r <= sync2_r[g];
                dcnt_r  <= {DW{1'b0}};
            end else begin
                dcnt_r  <= dcnt_r + DW'(1);
            end
        end

        // Press/repeat decision; rcnt counts only enabled cycles since the last pulse
        always_comb begin
            state_s = state_r;
            rcnt_s  = rcnt_r;
            fire_s  = 1'b0;
            case (state_r)
                IDLE: begin
                    if (level_r) begin
                        fire_s  = 1'b1;
                        rcnt_s  = {RW{1'b0}};
                        state_s = HOLD;
                    end else begin
                        rcnt_s  = {RW{1'b0}};
                    end
                end
                HOLD: begin
                    if (!level_r) begin
                        state_s = IDLE;
                    end else if (bus.repeat_en && (rcnt_r == DELAY_LAST)) begin
                        fire_s  = 1'b1;
                        rcnt_s  = {RW{1'b0}};
                        state_s = REPEAT;
                    end else if (bus.repeat_en) begin
                        rcnt_s  = rcnt_r + RW'(1);
                    end else begin
                        rcnt_s  = rcnt_r;
                    end
                end
                REPEAT: begin
                    if (!level_r) begin
                        state_s = IDLE;
                    end else if (!bus.repeat_en) begin
                        rcnt_s  = {RW{1'b0}};
                        state_s = HOLD;
                    end else if (rcnt_r == PERIOD_LAST) begin
                        fire_s  = 1'b1;
                        rcnt_s  = {RW{1'b0}};
                    end else begin
                        rcnt_s  = rcnt_r + RW'(1);
                    end
                end
                default: begin
                    state_s = IDLE;
                    rcnt_s  = {RW{1'b0}};
                end
            endcase
        end

        // Channel state, repeat counter and registered pulse
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_r <= IDLE;
                rcnt_r  <= {RW{1'b0}};
                pulse_r <= 1'b0;
            end else begin
                state_r <= state_s;
                rcnt_r  <= rcnt_s;
                pulse_r <= fire_s;
            end
        end

        assign level_s[g] = level_r;
        assign pulse_s[g] = pulse_r;
    end

    assign bus.level = level_s;
    assign bus.pulse = pulse_s;
endmodule
